posit_decoder: RTL and testbench
================================

# posit_decoder

Pipelined posit-to-field decoder that turns an N-bit posit word into the sign, total exponent (te) and mantissa (hidden bit included) consumed by the add/sub core. It sits between the PPU operand registers and the arithmetic cores, and is instantiated once per operand. It is a 2-stage elastic pipeline with valid/ready handshakes on both sides, sustaining one word per cycle.

## Interface
- N, 16, posit width in bits (8..32)
- ES, 1, exponent field width (0..3)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  decoder can accept `in_bits` this cycle
- in_bits  in  N  posit word
- out_valid  out  1  decoded fields valid
- out_ready  in  1  consumer accepts fields this cycle
- out_sign  out  1  posit sign
- out_te  out  TE_W = $clog2(N)+ES+1  signed total exponent, k·2^ES + e
- out_mant  out  MANT_W = N-ES-2  mantissa, hidden 1 at MSB, fraction left-aligned
- out_is_zero  out  1  word was 0
- out_is_nar  out  1  word was NaR (1 followed by N-1 zeros)
- nar_count  out  16  only with PPU_DECODER_NAR_CNT_EN (see Configuration)

## Operation
- Stage 1 (S1): capture word; sign = MSB; magnitude = two's complement of word if sign=1; flag zero/NaR.
- Stage 2 (S2): regime = run of identical bits after sign, length m, terminated by opposite bit or end of word. k = m-1 for a run of ones, k = -m for a run of zeros.
- Next ES bits are e. Bits missing because the regime consumed the word read as 0.
- Remaining bits are the fraction, left-aligned below the hidden 1, zero-padded.
- te = k·2^ES + e, sign-extended to TE_W. No rounding or truncation occurs; every legal posit fits.
- Zero: is_zero=1, sign=0, te=0, mant=0. NaR: is_nar=1, sign=1, te=0, mant=0.
- Flags are mutually exclusive.

## Timing
- Latency: 2 cycles from input handshake to out_valid when out_ready=1.
- Throughput: 1 word/cycle.
- Stage advance: S2 loads when S2 is empty or out_ready=1. S1 loads when S1 is empty or S1 advances.
- in_ready = !rst && (!s1_valid || s1_advance). It is combinational from out_ready.
- Under stall, at most 2 words are held. Order is preserved. Held outputs are stable while out_valid && !out_ready.
- Reset (including mid-operation): all in-flight words are dropped. Next cycle: out_valid=0, all out_* =0, nar_count=0. in_ready=0 while rst=1.

## Configuration
- PPU_DECODER_NAR_CNT_EN defined: port nar_count exists. It is a 16-bit counter that increments on each accepted input NaR word (in_valid && in_ready) and saturates at 0xFFFF. Reset value 0.
- Not defined: the port and counter are absent. Decode behaviour is identical.

## Structure
- ppu_pkg holds:
  - functions te_width(N,ES) and mant_width(N,ES)
  - NaR pattern function
  - packed struct posit_fields_t {sign, te, mant, is_zero, is_nar}, shared with the add/sub and encoder paths
- Sub-module lzc: parameterized leading-zero counter over N-1 bits with a count output. S2 uses it on the magnitude, XOR-inverted by the first regime bit.

## Test plan (N=16, ES=1)
- 0x4000, 0x5000, 0x4800 back-to-back with out_ready=1 → three outputs on consecutive cycles, 2 cycles after each input:
  - te=0, mant=0x1000
  - te=1, mant=0x1000
  - te=0, mant=0x1800
  - sign=0 for all
- 0xC000 → sign=1, te=0, mant=0x1000. 0x7FFF → te=28, mant=0x1000. 0x0001 → te=-28, mant=0x1000.
- 0x0000 → is_zero=1, te=0, mant=0, sign=0. 0x8000 → is_nar=1, sign=1. With the macro defined, nar_count=1.
- out_ready=0 while offering 4 words → exactly 2 accepted, then in_ready=0 and outputs stable. Raise out_ready → both emerge in order, then the remaining 2 are accepted.
- rst asserted for 1 cycle with 2 words in flight → next cycle out_valid=0, all outputs 0. The words are never emitted, and a new input decodes with 2-cycle latency.
- 0x0003 (regime 13 zeros, then 1, then e=1) → te=-25, mant=0x1000. Checks that truncated exponent and fraction bits are zero-filled.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared posit helpers and the decoded-field bundle used by the PPU decoder, add/sub and encoder paths.
// Field widths in posit_fields_t are sized for the largest supported posit (N=32); narrower users take the low bits.
package ppu_pkg;

    localparam int PPU_N_MAX  = 32;
    localparam int PPU_ES_MAX = 3;

    function automatic int te_width(input int n, input int es);
        return $clog2(n) + es + 1;
    endfunction

    function automatic int mant_width(input int n, input int es);
        return n - es - 2;
    endfunction

    localparam int TE_MAX_W   = te_width(PPU_N_MAX, PPU_ES_MAX);
    localparam int MANT_MAX_W = mant_width(PPU_N_MAX, 0);

    // NaR is the sign bit alone: 1 followed by n-1 zeros.
    function automatic logic [PPU_N_MAX-1:0] nar_pattern(input int n);
        return {{(PPU_N_MAX-1){1'b0}}, 1'b1} << (n - 1);
    endfunction

    typedef struct packed {
        logic                         sign;
        logic signed [TE_MAX_W-1:0]   te;
        logic        [MANT_MAX_W-1:0] mant;
        logic                         is_zero;
        logic                         is_nar;
    } posit_fields_t;

endpackage

// File: rtl/posit_decoder_lzc.sv
// Leading-zero counter over W bits; an all-zero input reports W.
module lzc #(
    parameter int W  = 15,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Later iterations win, so the highest set bit decides the count.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/posit_decoder.sv
// Two-stage elastic posit decoder: S1 takes sign/magnitude and special cases, S2 splits regime, exponent and fraction.
// Define PPU_DECODER_NAR_CNT_EN to add the saturating nar_count port.
module posit_decoder
    import ppu_pkg::*;
#(
    parameter int N  = 16,
    parameter int ES = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [N-1:0]                       in_bits,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_sign,
    output logic signed [te_width(N, ES)-1:0]  out_te,
    output logic [mant_width(N, ES)-1:0]       out_mant,
    output logic                               out_is_zero,
`ifdef PPU_DECODER_NAR_CNT_EN
    output logic                               out_is_nar,
    output logic [15:0]                        nar_count
`else
    output logic                               out_is_nar
`endif
);

    localparam int TE_W   = te_width(N, ES);
    localparam int MANT_W = mant_width(N, ES);
    localparam int CW     = $clog2(N);
    localparam logic [N-1:0] NAR = N'(nar_pattern(N));

    logic         s1_valid;
    logic         s1_sign;
    logic         s1_zero;
    logic         s1_nar;
    logic [N-2:0] s1_mag;

    logic          s2_valid;
    posit_fields_t s2_fields;

    logic s2_load;
    logic s1_advance;
    logic s1_load;

    assign s2_load    = !s2_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign s1_load    = !s1_valid || s1_advance;
    assign in_ready   = !rst && s1_load;

    // Only the low N-1 magnitude bits are kept; the magnitude MSB is nonzero only for NaR, which is flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_mag   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_bits[N-1];
                s1_mag  <= in_bits[N-1] ? -in_bits[N-2:0] : in_bits[N-2:0];
                s1_zero <= (in_bits == '0);
                s1_nar  <= (in_bits == NAR);
            end
        end
    end

    logic [N-2:0]           regime_scan;
    logic [CW-1:0]          run_len;
    logic [N-4:0]           body;
    logic signed [TE_W-1:0] k_val;
    logic signed [TE_W-1:0] e_val;
    logic signed [TE_W-1:0] te_val;
    logic [MANT_W-1:0]      mant_val;
    posit_fields_t          dec_fields;

    // Flipping by the first regime bit turns either kind of run into leading zeros.
    assign regime_scan = s1_mag ^ {(N-1){s1_mag[N-2]}};

    lzc #(
        .W  (N - 1),
        .CW (CW)
    ) u_lzc (
        .value (regime_scan),
        .count (run_len)
    );

    // The first two bits after the sign always belong to the regime or its terminator,
    // so shifting the rest by run_len-1 left-aligns exponent then fraction, zero-filled.
    assign body  = s1_mag[N-4:0] << (run_len - CW'(1));
    assign k_val = s1_mag[N-2] ? TE_W'(run_len) - TE_W'(1) : -TE_W'(run_len);

    if (ES > 0) begin : g_exp
        assign e_val    = TE_W'(body[N-4 -: ES]);
        assign mant_val = {1'b1, body[N-4-ES:0]};
    end else begin : g_no_exp
        assign e_val    = '0;
        assign mant_val = {1'b1, body};
    end

    assign te_val = (k_val <<< ES) + e_val;

    always_comb begin
        dec_fields         = '0;
        dec_fields.sign    = s1_sign;
        dec_fields.is_zero = s1_zero;
        dec_fields.is_nar  = s1_nar;
        if (!s1_zero && !s1_nar) begin
            dec_fields.te   = TE_MAX_W'(te_val);
            dec_fields.mant = MANT_MAX_W'(mant_val);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_fields <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_fields <= dec_fields;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_sign    = s2_fields.sign;
    assign out_te      = s2_fields.te[TE_W-1:0];
    assign out_mant    = s2_fields.mant[MANT_W-1:0];
    assign out_is_zero = s2_fields.is_zero;
    assign out_is_nar  = s2_fields.is_nar;

    // The shared bundle is wider than this instance needs; the upper bits are constant.
    logic unused_fields;
    assign unused_fields = ^s2_fields;

`ifdef PPU_DECODER_NAR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            nar_count <= '0;
        end else if (in_valid && in_ready && (in_bits == NAR) && (nar_count != 16'hFFFF)) begin
            nar_count <= nar_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_posit_decoder.sv
// Bench for posit_decoder at N=16, ES=1: directed steps plus random traffic, scored against a bit-walking posit model.
// Build with +define+PPU_DECODER_NAR_CNT_EN to also score nar_count.
module tb_posit_decoder;

    localparam int N      = 16;
    localparam int ES     = 1;
    localparam int TE_W   = 6;
    localparam int MANT_W = 13;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0]           in_bits;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_sign;
    logic signed [TE_W-1:0] out_te;
    logic [MANT_W-1:0]      out_mant;
    logic                   out_is_zero;
    logic                   out_is_nar;
`ifdef PPU_DECODER_NAR_CNT_EN
    logic [15:0]            nar_count;
`endif

    always #5 clk = ~clk;

    posit_decoder #(
        .N  (N),
        .ES (ES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bits     (in_bits),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_te      (out_te),
        .out_mant    (out_mant),
        .out_is_zero (out_is_zero),
`ifdef PPU_DECODER_NAR_CNT_EN
        .out_is_nar  (out_is_nar),
        .nar_count   (nar_count)
`else
        .out_is_nar  (out_is_nar)
`endif
    );

    typedef struct {
        logic [15:0] word;
        logic        sign;
        int          te;
        int          mant;
        logic        zero;
        logic        nar;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    int   nar_seen = 0;
    bit   lat_check = 1'b0;

    // Walks the word bit by bit exactly as the posit format is defined.
    function automatic exp_t refDecode(input logic [15:0] w);
        exp_t r;
        logic [15:0] v;
        logic reg_bit;
        int i, m, k, e, nf, frac;
        r.word = w; r.sign = 1'b0; r.te = 0; r.mant = 0;
        r.zero = 1'b0; r.nar = 1'b0; r.acc_cyc = 0;
        if (w == 16'h0000) begin
            r.zero = 1'b1;
            return r;
        end
        if (w == 16'h8000) begin
            r.nar  = 1'b1;
            r.sign = 1'b1;
            return r;
        end
        r.sign  = w[15];
        v       = w[15] ? -w : w;
        reg_bit = v[14];
        m = 0;
        i = 14;
        while (i >= 0 && v[i] == reg_bit) begin
            m++;
            i--;
        end
        i--;
        k = reg_bit ? m - 1 : -m;
        e = 0;
        for (int j = 0; j < ES; j++) begin
            e = e * 2 + ((i >= 0) ? int'(v[i]) : 0);
            i--;
        end
        nf     = (i >= 0) ? i + 1 : 0;
        frac   = int'(v) & ((1 << nf) - 1);
        r.te   = k * (1 << ES) + e;
        r.mant = (1 << (MANT_W - 1)) | (frac << (MANT_W - 1 - nf));
        return r;
    endfunction

    task automatic checkVal(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic checkOutput();
        exp_t x;
        if (sb.size() == 0) begin
            checkVal("unexpected_output", out_valid, 0);
            return;
        end
        x = sb.pop_front();
        checkVal($sformatf("sign[%h]", x.word), out_sign, x.sign);
        checkVal($sformatf("te[%h]", x.word), $signed(out_te), x.te);
        checkVal($sformatf("mant[%h]", x.word), out_mant, x.mant);
        checkVal($sformatf("is_zero[%h]", x.word), out_is_zero, x.zero);
        checkVal($sformatf("is_nar[%h]", x.word), out_is_nar, x.nar);
        if (lat_check) checkVal($sformatf("latency[%h]", x.word), cyc - x.acc_cyc, 2);
    endtask

    // One clock cycle: drive, score both handshakes just before the edge, then step past it.
    task automatic applyStimulus(input logic r, input logic iv, input logic [15:0] bits, input logic ordy);
        exp_t x;
        rst = r; in_valid = iv; in_bits = bits; out_ready = ordy;
        #1;
        if (!r && out_valid && out_ready) checkOutput();
        if (!r && in_valid && in_ready) begin
            x = refDecode(bits);
            x.acc_cyc = cyc;
            sb.push_back(x);
            acc_cnt++;
            if (bits == 16'h8000) nar_seen++;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (r) begin
            sb.delete();
            nar_seen = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
            n++;
        end
        checkVal("drain_left", sb.size(), 0);
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "_in_ready"}, in_ready, 0);
        checkVal({tag, "_out_valid"}, out_valid, 0);
        checkVal({tag, "_sign"}, out_sign, 0);
        checkVal({tag, "_te"}, $signed(out_te), 0);
        checkVal({tag, "_mant"}, out_mant, 0);
        checkVal({tag, "_flags"}, {out_is_zero, out_is_nar}, 0);
`ifdef PPU_DECODER_NAR_CNT_EN
        checkVal({tag, "_nar_count"}, nar_count, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] dir_words[6];
        logic [15:0] stall_words[4];
        logic [15:0] cur;
        logic        snap_valid;
        logic [5:0]  snap_te;
        logic [12:0] snap_mant;
        int acc0, idx, n;

        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkResetState("reset");

        lat_check = 1'b1;
        acc0 = acc_cnt;
        applyStimulus(1'b0, 1'b1, 16'h4000, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h5000, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h4800, 1'b1);
        checkVal("b2b_accepted", acc_cnt - acc0, 3);
        drain(10);

        dir_words = '{16'hC000, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 16'h0003};
        acc0 = acc_cnt;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, dir_words[i], 1'b1);
        checkVal("dir_accepted", acc_cnt - acc0, 6);
        drain(10);
`ifdef PPU_DECODER_NAR_CNT_EN
        checkVal("nar_count_directed", nar_count, 1);
`endif

        lat_check = 1'b0;
        stall_words = '{16'h6000, 16'h3000, 16'hA000, 16'h1234};
        acc0 = acc_cnt;
        idx = 0;
        snap_valid = 1'b0; snap_te = '0; snap_mant = '0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, idx < 4, (idx < 4) ? stall_words[idx] : 16'h0000, 1'b0);
            idx = acc_cnt - acc0;
            if (c == 1) begin
                snap_valid = out_valid;
                snap_te    = out_te;
                snap_mant  = out_mant;
            end
        end
        checkVal("stall_accepted", acc_cnt - acc0, 2);
        checkVal("stall_in_ready", in_ready, 0);
        checkVal("stall_out_valid", out_valid, 1);
        checkVal("stall_valid_stable", out_valid, snap_valid);
        checkVal("stall_te_stable", out_te, snap_te);
        checkVal("stall_mant_stable", out_mant, snap_mant);
        n = 0;
        while (idx < 4 && n < 20) begin
            applyStimulus(1'b0, 1'b1, stall_words[idx], 1'b1);
            idx = acc_cnt - acc0;
            n++;
        end
        checkVal("stall_all_accepted", acc_cnt - acc0, 4);
        drain(10);

        applyStimulus(1'b0, 1'b1, 16'h4000, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h5000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkResetState("midrst");
        lat_check = 1'b1;
        acc0 = acc_cnt;
        applyStimulus(1'b0, 1'b1, 16'h3800, 1'b1);
        checkVal("post_rst_accepted", acc_cnt - acc0, 1);
        drain(10);

        lat_check = 1'b0;
        cur = 16'($urandom);
        for (int c = 0; c < 300; c++) begin
            logic iv;
            logic ordy;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            acc0 = acc_cnt;
            applyStimulus(1'b0, iv, cur, ordy);
            if (acc_cnt != acc0) begin
                case ($urandom_range(0, 9))
                    0:       cur = 16'h0000;
                    1:       cur = 16'h8000;
                    2:       cur = 16'h7FFF;
                    3:       cur = 16'h0001;
                    default: cur = 16'($urandom);
                endcase
            end
        end
        drain(20);
`ifdef PPU_DECODER_NAR_CNT_EN
        checkVal("nar_count_random", nar_count, nar_seen);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
